// File: rtl/bcp_pe_mq.sv
// BCP processing element: pops one assigned literal, walks its watch list node by node and
// emits implications (valid/ready), conflicts, done or err pulses; requests stall on halt.
module bcp_pe_mq #(
    parameter int K        = 4,
    parameter int LW       = 8,
    parameter int PW       = 10,
    parameter int MAX_HOPS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                halt,
    input  logic                lit_valid,
    input  logic [LW-1:0]       lit,
    output logic                lit_ready,
    output logic                init_req,
    output logic [LW-1:0]       init_lit,
    input  logic                init_rsp_valid,
    input  logic [PW-1:0]       init_rsp_ptr,
    output logic                node_req,
    output logic [PW-1:0]       node_addr,
    input  logic                node_rsp_valid,
    input  logic [K*LW-1:0]     node_rsp_cla,
    input  logic [K*PW-1:0]     node_rsp_ptr,
    output logic [K*(LW-1)-1:0] gst_var,
    input  logic [2*K-1:0]      gst_state,
    output logic                imp_valid,
    output logic [LW-1:0]       imp_lit,
    input  logic                imp_ready,
    output logic                conflict,
    output logic [PW-1:0]       conflict_ptr,
    output logic                done,
    output logic                err,
    output logic                busy
);

    localparam int HW = $clog2(MAX_HOPS + 1);
    localparam int VW = LW - 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, FETCH, EVAL, EMIT} state_t;
    typedef enum logic [1:0] {ACT_DONE, ACT_ERR, ACT_NEXT} act_t;

    state_t          state_q, state_d;
    act_t            act_q, act_d, act_sel, eval_act;
    logic [LW-1:0]   cur_lit_q, cur_lit_d, imp_lit_q, imp_lit_d;
    logic [HW-1:0]   hop_q, hop_d, hop_inc;
    logic [K*LW-1:0] cla_q, cla_d;
    logic [K*PW-1:0] ptrs_q, ptrs_d;
    logic [PW-1:0]   node_ptr_q, node_ptr_d, conflict_ptr_q, conflict_ptr_d;
    logic            init_pend_q, init_pend_d, node_pend_q, node_pend_d;
    logic            imp_valid_q, imp_valid_d, conflict_q, conflict_d;
    logic            done_q, done_d, err_q, err_d;

    logic            do_act;
    logic [PW-1:0]   launch_addr;
    logic            watch_found, any_true, undef_seen, undef_multi;
    logic [LW-1:0]   undef_lit, slot_lit, var_lit;
    logic [PW-1:0]   watch_ptr;
    logic [1:0]      slot_st;
    logic            imp_now, conflict_now;

    always_comb begin
        gst_var = '0;
        for (int i = 0; i < K; i++) begin
            var_lit = cla_q[i*LW +: LW];
            gst_var[i*VW +: VW] = var_lit[LW-1] ? VW'(-var_lit) : var_lit[VW-1:0];
        end
    end

    // Per-node evaluation; empty slots (literal 0) take no part.
    always_comb begin
        watch_found = 1'b0;
        watch_ptr   = '0;
        any_true    = 1'b0;
        undef_seen  = 1'b0;
        undef_multi = 1'b0;
        undef_lit   = '0;
        slot_lit    = '0;
        slot_st     = '0;
        for (int i = 0; i < K; i++) begin
            slot_lit = cla_q[i*LW +: LW];
            slot_st  = gst_state[2*i +: 2];
            if (slot_lit != '0) begin
                if (!watch_found && slot_lit == cur_lit_q) begin
                    watch_found = 1'b1;
                    watch_ptr   = ptrs_q[i*PW +: PW];
                end
                if ((!slot_lit[LW-1] && slot_st == 2'd1) || (slot_lit[LW-1] && slot_st == 2'd2))
                    any_true = 1'b1;
                if (slot_st == 2'd0) begin
                    if (undef_seen) undef_multi = 1'b1;
                    undef_seen = 1'b1;
                    undef_lit  = slot_lit;
                end
            end
        end
        imp_now      = !any_true && undef_seen && !undef_multi;
        conflict_now = !any_true && !undef_seen;
        hop_inc      = hop_q + HW'(1);
        if (watch_ptr == '0)                eval_act = ACT_DONE;
        else if (hop_inc == HW'(MAX_HOPS))  eval_act = ACT_ERR;
        else                                eval_act = ACT_NEXT;
    end

    always_comb begin
        state_d        = state_q;
        act_d          = act_q;
        cur_lit_d      = cur_lit_q;
        imp_lit_d      = imp_lit_q;
        hop_d          = hop_q;
        cla_d          = cla_q;
        ptrs_d         = ptrs_q;
        node_ptr_d     = node_ptr_q;
        conflict_ptr_d = conflict_ptr_q;
        init_pend_d    = init_pend_q;
        node_pend_d    = node_pend_q;
        imp_valid_d    = imp_valid_q;
        conflict_d     = 1'b0;
        done_d         = 1'b0;
        err_d          = 1'b0;
        init_req       = 1'b0;
        node_req       = 1'b0;
        node_addr      = '0;
        do_act         = 1'b0;
        act_sel        = ACT_DONE;
        launch_addr    = '0;
        lit_ready      = (state_q == IDLE || !rst_n) && !halt && !flush && (lit != '0);

        case (state_q)
            IDLE: begin
                if (lit_valid && lit_ready) begin
                    cur_lit_d   = lit;
                    hop_d       = '0;
                    init_pend_d = 1'b1;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (init_pend_q) begin
                    if (!halt) begin
                        init_req    = 1'b1;
                        init_pend_d = 1'b0;
                    end
                end else if (init_rsp_valid) begin
                    if (init_rsp_ptr == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        do_act      = 1'b1;
                        act_sel     = ACT_NEXT;
                        launch_addr = init_rsp_ptr;
                    end
                end
            end
            FETCH: begin
                if (node_pend_q) begin
                    if (!halt) begin
                        node_req    = 1'b1;
                        node_addr   = node_ptr_q;
                        node_pend_d = 1'b0;
                    end
                end else if (node_rsp_valid) begin
                    cla_d   = node_rsp_cla;
                    ptrs_d  = node_rsp_ptr;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (!watch_found) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (conflict_now) begin
                    conflict_d     = 1'b1;
                    conflict_ptr_d = node_ptr_q;
                    state_d        = IDLE;
                end else begin
                    if (watch_ptr != '0) hop_d = hop_inc;
                    // Park the follow-up action until the implication is taken.
                    if (imp_now) begin
                        imp_valid_d = 1'b1;
                        imp_lit_d   = undef_lit;
                        act_d       = eval_act;
                        node_ptr_d  = watch_ptr;
                        state_d     = EMIT;
                    end else begin
                        do_act      = 1'b1;
                        act_sel     = eval_act;
                        launch_addr = watch_ptr;
                    end
                end
            end
            EMIT: begin
                if (imp_ready) begin
                    imp_valid_d = 1'b0;
                    do_act      = 1'b1;
                    act_sel     = act_q;
                    launch_addr = node_ptr_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_act) begin
            case (act_sel)
                ACT_DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                ACT_ERR: begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d    = FETCH;
                    node_ptr_d = launch_addr;
                    if (halt) begin
                        node_pend_d = 1'b1;
                    end else begin
                        node_req    = 1'b1;
                        node_addr   = launch_addr;
                        node_pend_d = 1'b0;
                    end
                end
            endcase
        end

        if (flush) begin
            state_d     = IDLE;
            init_pend_d = 1'b0;
            node_pend_d = 1'b0;
            imp_valid_d = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            conflict_d  = 1'b0;
            init_req    = 1'b0;
            node_req    = 1'b0;
            node_addr   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            act_q          <= ACT_DONE;
            cur_lit_q      <= '0;
            imp_lit_q      <= '0;
            hop_q          <= '0;
            cla_q          <= '0;
            ptrs_q         <= '0;
            node_ptr_q     <= '0;
            conflict_ptr_q <= '0;
            init_pend_q    <= 1'b0;
            node_pend_q    <= 1'b0;
            imp_valid_q    <= 1'b0;
            conflict_q     <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            act_q          <= act_d;
            cur_lit_q      <= cur_lit_d;
            imp_lit_q      <= imp_lit_d;
            hop_q          <= hop_d;
            cla_q          <= cla_d;
            ptrs_q         <= ptrs_d;
            node_ptr_q     <= node_ptr_d;
            conflict_ptr_q <= conflict_ptr_d;
            init_pend_q    <= init_pend_d;
            node_pend_q    <= node_pend_d;
            imp_valid_q    <= imp_valid_d;
            conflict_q     <= conflict_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign init_lit     = init_req ? cur_lit_q : '0;
    assign imp_valid    = imp_valid_q;
    assign imp_lit      = imp_lit_q;
    assign conflict     = conflict_q;
    assign conflict_ptr = conflict_ptr_q;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bcp_pe_mq.sv
// Directed bench for bcp_pe_mq with a behavioural watch-list memory and state table.
module tb_bcp_pe_mq;
    localparam int K = 4, LW = 8, PW = 10, MAX_HOPS = 4;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, halt = 1'b0;
    logic lit_valid = 1'b0, imp_ready = 1'b1;
    logic [LW-1:0] lit = '0;
    logic lit_ready, init_req, node_req, imp_valid, conflict, done, err, busy;
    logic [LW-1:0] init_lit, imp_lit;
    logic init_rsp_valid = 1'b0, node_rsp_valid = 1'b0;
    logic [PW-1:0] init_rsp_ptr = '0, node_addr, conflict_ptr;
    logic [K*LW-1:0] node_rsp_cla = '0;
    logic [K*PW-1:0] node_rsp_ptr = '0;
    logic [K*(LW-1)-1:0] gst_var;
    logic [2*K-1:0] gst_state;

    bcp_pe_mq #(.K(K), .LW(LW), .PW(PW), .MAX_HOPS(MAX_HOPS)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .halt(halt),
        .lit_valid(lit_valid), .lit(lit), .lit_ready(lit_ready),
        .init_req(init_req), .init_lit(init_lit),
        .init_rsp_valid(init_rsp_valid), .init_rsp_ptr(init_rsp_ptr),
        .node_req(node_req), .node_addr(node_addr),
        .node_rsp_valid(node_rsp_valid), .node_rsp_cla(node_rsp_cla), .node_rsp_ptr(node_rsp_ptr),
        .gst_var(gst_var), .gst_state(gst_state),
        .imp_valid(imp_valid), .imp_lit(imp_lit), .imp_ready(imp_ready),
        .conflict(conflict), .conflict_ptr(conflict_ptr),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [K*LW-1:0] mem_cla [0:1023];
    logic [K*PW-1:0] mem_ptr [0:1023];
    logic [PW-1:0]   head    [0:255];
    logic [1:0]      st      [0:127];

    always_comb begin
        gst_state = '0;
        for (int i = 0; i < K; i++) gst_state[2*i +: 2] = st[gst_var[i*(LW-1) +: (LW-1)]];
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int n_nreq = 0, n_done = 0, n_err = 0, n_conf = 0, n_imp = 0, n_unst = 0;
    int nreq_cyc = 0, done_cyc = 0, acc_cyc = 0, hs_cyc = 0;
    logic [PW-1:0] nreq_addr = '0, conf_ptr = '0;
    logic [LW-1:0] last_il = '0, prev_il = '0;
    logic prev_iv = 1'b0, init_seen = 1'b0, node_seen = 1'b0, auto_node = 1'b1;
    logic [LW-1:0] init_seen_lit = '0;
    logic [PW-1:0] node_seen_addr = '0;
    int late_cnt = 0, late_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (node_req) begin n_nreq++; nreq_cyc = cyc; nreq_addr = node_addr; end
            if (done) begin n_done++; done_cyc = cyc; end
            if (err) n_err++;
            if (conflict) begin n_conf++; conf_ptr = conflict_ptr; end
            if (imp_valid) begin
                n_imp++;
                if (prev_iv && imp_lit != prev_il) n_unst++;
                last_il = imp_lit;
                if (imp_ready) hs_cyc = cyc;
            end
            if (lit_valid && lit_ready) acc_cyc = cyc;
        end
        prev_iv        = imp_valid;
        prev_il        = imp_lit;
        init_seen      = init_req;
        init_seen_lit  = init_lit;
        node_seen      = node_req;
        node_seen_addr = node_addr;
    end

    // Memory side answers one cycle after each request.
    always @(posedge clk) begin
        #1;
        init_rsp_valid = init_seen;
        init_rsp_ptr   = init_seen ? head[init_seen_lit] : '0;
        node_rsp_valid = 1'b0;
        if (node_seen && auto_node) begin
            node_rsp_valid = 1'b1;
            node_rsp_cla   = mem_cla[node_seen_addr];
            node_rsp_ptr   = mem_ptr[node_seen_addr];
        end else if (late_cnt != late_done) begin
            late_done      = late_cnt;
            node_rsp_valid = 1'b1;
            node_rsp_cla   = mem_cla[5];
            node_rsp_ptr   = mem_ptr[5];
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_lit(input logic [LW-1:0] l);
        bit ok = 1'b0;
        lit = l;
        lit_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (lit_ready) ok = 1'b1;
            tick();
        end
        lit_valid = 1'b0;
        chk("accept", 32'(ok), 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
            tick();
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic wait_imp(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imp_valid) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 1);
    endtask

    int b_done, b_err, b_conf, b_imp, b_nreq;
    task automatic snap();
        b_done = n_done; b_err = n_err; b_conf = n_conf; b_imp = n_imp; b_nreq = n_nreq;
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 1024; i++) begin mem_cla[i] = '0; mem_ptr[i] = '0; end
        for (int i = 0; i < 256; i++) head[i] = '0;
        for (int i = 0; i < 128; i++) st[i] = 2'd0;
        mem_cla[5]  = {8'd7, 8'd0, 8'hFB, 8'd3};
        mem_ptr[5]  = '0;
        mem_cla[10] = {8'd0, 8'd8, 8'hFA, 8'd4};
        mem_ptr[10] = {10'd0, 10'd0, 10'd0, 10'd20};
        mem_cla[20] = {8'd0, 8'd9, 8'd4, 8'd0};
        mem_ptr[20] = {10'd0, 10'd0, 10'd0, 10'd33};
        mem_cla[40] = {8'd0, 8'd0, 8'd0, 8'd2};
        mem_ptr[40] = {10'd0, 10'd0, 10'd0, 10'd40};
        head[3] = 10'd0; head[4] = 10'd10; head[2] = 10'd40;
        st[2] = 2'd1; st[3] = 2'd2; st[4] = 2'd2; st[5] = 2'd1; st[6] = 2'd1; st[9] = 2'd1;

        // Reset state
        lit = 8'd5;
        tick(); tick();
        @(negedge clk);
        chk("rst_lit_ready", 32'(lit_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_reqs", 32'({init_req, node_req}), 0);
        chk("rst_pulses", 32'({imp_valid, done, err, conflict}), 0);
        halt = 1'b1;
        @(negedge clk);
        chk("rst_halt_rdy", 32'(lit_ready), 0);
        tick();
        halt = 1'b0;
        rst_n = 1'b1;
        lit = 8'd0;
        lit_valid = 1'b1;
        @(negedge clk);
        chk("zero_lit_rdy", 32'(lit_ready), 0);
        tick();
        lit_valid = 1'b0;

        // Empty watch list
        snap();
        send_lit(8'd3);
        wait_idle("t1_idle");
        chk("t1_done", n_done - b_done, 1);
        chk("t1_done_lat", done_cyc - acc_cyc, 3);
        chk("t1_nreq", n_nreq - b_nreq, 0);

        // Single node, implication +7
        head[3] = 10'd5;
        snap();
        send_lit(8'd3);
        wait_idle("t2_idle");
        chk("t2_imp_cycles", n_imp - b_imp, 1);
        chk("t2_imp_lit", 32'(last_il), 7);
        chk("t2_done", n_done - b_done, 1);
        chk("t2_conf", n_conf - b_conf, 0);
        chk("t2_nreq", n_nreq - b_nreq, 1);

        // Same node, conflict
        st[7] = 2'd2;
        snap();
        send_lit(8'd3);
        wait_idle("t3_idle");
        chk("t3_conf", n_conf - b_conf, 1);
        chk("t3_conf_ptr", 32'(conf_ptr), 5);
        chk("t3_done", n_done - b_done, 0);
        chk("t3_imp", n_imp - b_imp, 0);
        st[7] = 2'd0;

        // Two-node chain with implication backpressure
        snap();
        imp_ready = 1'b0;
        send_lit(8'd4);
        wait_imp("t4_imp_seen");
        tick(); tick(); tick(); tick();
        imp_ready = 1'b1;
        wait_idle("t4_idle");
        chk("t4_imp_cycles", n_imp - b_imp, 5);
        chk("t4_imp_stable", n_unst, 0);
        chk("t4_imp_lit", 32'(last_il), 8);
        chk("t4_nreq", n_nreq - b_nreq, 2);
        chk("t4_nreq_addr", 32'(nreq_addr), 20);
        chk("t4_req_after_hs", 32'(nreq_cyc >= hs_cyc), 1);
        chk("t4_done", n_done - b_done, 1);

        // Self-loop hits hop limit
        snap();
        send_lit(8'd2);
        wait_idle("t5_idle");
        chk("t5_nreq", n_nreq - b_nreq, 4);
        chk("t5_err", n_err - b_err, 1);
        chk("t5_done", n_done - b_done, 0);

        // Flush in FETCH, late response ignored
        auto_node = 1'b0;
        snap();
        send_lit(8'd3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (node_req) begin ok = 1'b1; break; end
        end
        chk("t6_nreq_seen", 32'(ok), 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("t6_flush_idle", 32'(busy), 0);
        late_cnt++;
        tick(); tick(); tick();
        @(negedge clk);
        chk("t6_late_busy", 32'(busy), 0);
        tick();
        chk("t6_no_pulses", (n_done - b_done) + (n_err - b_err) + (n_conf - b_conf) + (n_imp - b_imp), 0);
        auto_node = 1'b1;
        snap();
        send_lit(8'd3);
        wait_idle("t6b_idle");
        chk("t6b_done", n_done - b_done, 1);
        chk("t6b_imp_lit", 32'(last_il), 7);

        // Reset in mid-walk
        imp_ready = 1'b0;
        send_lit(8'd4);
        wait_imp("t7_imp_seen");
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_pulses", 32'({imp_valid, done, err, conflict, init_req, node_req}), 0);
        chk("t7_vals", 32'(imp_lit) + 32'(conflict_ptr) + 32'(node_addr) + 32'(gst_var), 0);
        chk("t7_lit_ready", 32'(lit_ready), 1);
        tick();
        rst_n = 1'b1;
        imp_ready = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bcp_pe_mq.md
# bcp_pe_mq

Parametrised second-generation Boolean Constraint Propagation processing element. It pops one assigned literal from the unit-clause arbiter and walks that literal's watch list in clause memory. For each clause node it evaluates the literal states returned by the global state table and emits implications or conflicts. It sits between the UCQ_OUT arbiter, the clause-list memory and the global state table, and adds the following:
- real request/response handshakes
- an implication output with backpressure
- a loop guard
- a flush path

## Interface
Parameters:
- K, 4: literal slots per clause node.
- LW, 8: literal width; signed two's complement; 0 means an empty slot.
- PW, 10: node pointer width; pointer 0 means end of list.
- MAX_HOPS, 256: maximum nodes visited per literal before the loop error fires.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous abort to IDLE.
- halt  in  1  blocks new literal accepts and new memory requests.
- lit_valid  in  1  new assigned literal offered.
- lit  in  LW  literal value.
- lit_ready  out  1  PE accepts the literal.
- init_req  out  1  one-cycle watch-list head lookup request.
- init_lit  out  LW  literal being looked up.
- init_rsp_valid  in  1  head pointer response valid.
- init_rsp_ptr  in  PW  head pointer.
- node_req  out  1  one-cycle node read request.
- node_addr  out  PW  node pointer being read.
- node_rsp_valid  in  1  node response valid.
- node_rsp_cla  in  K*LW  clause literals.
- node_rsp_ptr  in  K*PW  next pointer per slot.
- gst_var  out  K*(LW-1)  variable index |lit| per slot, combinational from the node register.
- gst_state  in  2K  per-slot variable state, combinational, same cycle: 0=UNDEF, 1=TRUE, 2=FALSE.
- imp_valid  out  1  implication valid.
- imp_lit  out  LW  implied literal.
- imp_ready  in  1  consumer accepts the implication.
- conflict  out  1  one-cycle pulse.
- conflict_ptr  out  PW  node that produced the conflict.
- done  out  1  one-cycle pulse when the watch-list walk ends normally.
- err  out  1  one-cycle pulse on a missing watch slot or a hop overflow.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, LOOKUP, FETCH, EVAL, EMIT.
- IDLE:
  - lit_ready = !halt.
  - On accept, latch the literal into cur_lit, clear the hop counter, and go to LOOKUP.
  - The literal value 0 is never accepted; lit_ready stays 0 for it.
- LOOKUP:
  - init_req pulses on the first cycle of LOOKUP, held off while halt is high.
  - On init_rsp_valid: a pointer of 0 gives done and goes to IDLE; otherwise pulse node_req with node_addr equal to the pointer and go to FETCH.
- FETCH: on node_rsp_valid, register the clause literals and pointers, save the node address, and go to EVAL.
- EVAL, single cycle. Slots holding literal 0 are ignored.
  - A slot is true when (lit>0 and state TRUE) or (lit<0 and state FALSE).
  - watch slot = lowest slot index whose literal equals cur_lit.
  - If no slot matches: err, then IDLE; no conflict or implication is issued.
  - If no slot is true and none is UNDEF: conflict pulse with conflict_ptr equal to the node address, then IDLE. The walk stops without a done pulse.
  - If no slot is true and exactly one is UNDEF: present imp_lit as that slot's literal with imp_valid.
  - next pointer = ptr[watch slot]. If it is 0, the walk ends: done.
  - Otherwise increment the hop counter. If the count reaches MAX_HOPS: err, then IDLE. Otherwise pulse node_req and go to FETCH.
- Implication backpressure:
  - If imp_valid and !imp_ready in EVAL, go to EMIT.
  - EMIT holds imp_valid and imp_lit stable until imp_ready, then takes the pending next-pointer action recorded in EVAL.
- halt: in-flight responses are still captured; only request pulses and lit accepts are delayed. A delayed request fires on the first cycle halt is low.
- flush:
  - Go to IDLE next cycle from any state.
  - Drop any pending implication.
  - Assert no done, conflict or err.
  - Ignore responses that arrive later until the next request.

## Timing
- Reset (rst_n=0 at a clock edge):
  - State is IDLE and all registers are cleared.
  - lit_ready=1 during reset, gated by halt.
  - All other outputs are 0.
- A reset in mid-walk behaves like flush.
- Cycle counts, no stalls:
  - accept at cycle t, init_req at t+1;
  - response at t+1+a;
  - node_req in the same cycle as the response;
  - node response r cycles later;
  - EVAL one cycle after the response.
- Per node, minimum 3 cycles: request, response, EVAL.
- imp_valid, conflict, done and err are registered and appear on the cycle after EVAL.
- Simultaneous flush and imp_ready in EMIT: flush wins and the implication is lost.
- Simultaneous halt and lit_valid in IDLE: no accept.

## Test plan
- Head pointer 0 for lit=+3 → done 3 cycles after accept; no node_req.
- Single node cla {+3,-5,0,+7}, ptr {0,...}, states var5=TRUE, var7=UNDEF, cur_lit=+3 → imp_lit=+7 one cycle; done.
- Same node with var5=TRUE, var7=FALSE → conflict=1, conflict_ptr equal to the node address; no done.
- Two-node chain with imp_ready held low for 4 cycles → imp_valid stable 5 cycles; second node_req only after the handshake; done at the end.
- Self-loop (ptr points to its own node) with MAX_HOPS=4 → exactly 4 node_req, err pulse, IDLE.
- flush in FETCH, then a late node_rsp_valid → no EVAL; next literal accepted normally; rst_n low mid-walk → all outputs 0.
